// File: rtl/spike_encoder.sv
// Race-logic spike encoder: larger intensities fire earlier within one gamma cycle (active-low spikes).
// Optional step mode via `define SPIKE_ENC_STEP_EN (lanes stay low from fire tick through the last RUN tick).
module spike_encoder #(
  parameter int NUM_INPUTS = 4,
  parameter int VAL_W      = 3,
  parameter int REST_TICKS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_INPUTS*VAL_W-1:0]   in_values,
  output logic [NUM_INPUTS-1:0]         should_spike_out_l,
  output logic                          gamma_start,
  output logic                          gamma_done,
  output logic                          busy,
  output logic [$clog2(NUM_INPUTS+1)-1:0] fired_cnt
);

  localparam int CNT_W  = $clog2(NUM_INPUTS+1);
  localparam int REST_W = (REST_TICKS > 1) ? $clog2(REST_TICKS) : 1;
  localparam logic [VAL_W-1:0]  MAXV      = '1;
  localparam logic [REST_W-1:0] REST_LAST = REST_W'(REST_TICKS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, REST = 2'd2} state_t;

  state_t                        state, state_nx;
  logic [VAL_W-1:0]              tick, tick_nx;
  logic [REST_W-1:0]             rest_cnt, rest_nx;
  logic [NUM_INPUTS*VAL_W-1:0]   vals, vals_nx;
  logic [NUM_INPUTS-1:0]         fire, fire_nx;
  logic [NUM_INPUTS-1:0]         spike_l_nx;
  logic                          start_nx, done_nx;
  logic [CNT_W-1:0]              cnt_nx;

  function automatic logic [NUM_INPUTS-1:0] fire_at(input logic [NUM_INPUTS*VAL_W-1:0] v_all,
                                                     input logic [VAL_W-1:0] t);
    logic [VAL_W-1:0] v;
    fire_at = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      v = v_all[i*VAL_W +: VAL_W];
      fire_at[i] = (v != '0) && (v == MAXV - t);
    end
  endfunction

  // Lanes driven low at tick t: only the firing tick in pulse mode, fire tick onward in step mode
  function automatic logic [NUM_INPUTS-1:0] low_at(input logic [NUM_INPUTS*VAL_W-1:0] v_all,
                                                    input logic [VAL_W-1:0] t);
`ifdef SPIKE_ENC_STEP_EN
    logic [VAL_W-1:0] v;
    low_at = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      v = v_all[i*VAL_W +: VAL_W];
      low_at[i] = (v != '0) && (t >= MAXV - v);
    end
`else
    low_at = fire_at(v_all, t);
`endif
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_INPUTS-1:0] x);
    popcount = '0;
    for (int i = 0; i < NUM_INPUTS; i++) popcount = popcount + CNT_W'(x[i]);
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Next-state and next-output decode; outputs are computed one tick ahead so they land registered
  always_comb begin
    state_nx   = state;
    tick_nx    = tick;
    rest_nx    = rest_cnt;
    vals_nx    = vals;
    fire_nx    = '0;
    spike_l_nx = '1;
    start_nx   = 1'b0;
    done_nx    = 1'b0;
    cnt_nx     = fired_cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          vals_nx    = in_values;
          tick_nx    = '0;
          state_nx   = RUN;
          start_nx   = 1'b1;
          cnt_nx     = '0;
          fire_nx    = fire_at(in_values, '0);
          spike_l_nx = ~low_at(in_values, '0);
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        // fire holds the lanes shown this tick, so the count trails the spikes by one cycle
        cnt_nx = fired_cnt + popcount(fire);
        if (tick == MAXV) begin
          state_nx = REST;
          rest_nx  = '0;
          done_nx  = (REST_TICKS == 1);
        end else begin
          tick_nx    = tick + VAL_W'(1);
          fire_nx    = fire_at(vals, tick_nx);
          spike_l_nx = ~low_at(vals, tick_nx);
        end
      end
      REST: begin
        if (rest_cnt == REST_LAST) begin
          state_nx = IDLE;
        end else begin
          rest_nx = rest_cnt + REST_W'(1);
          done_nx = (rest_nx == REST_LAST);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      tick               <= '0;
      rest_cnt           <= '0;
      vals               <= '0;
      fire               <= '0;
      should_spike_out_l <= '1;
      gamma_start        <= 1'b0;
      gamma_done         <= 1'b0;
      fired_cnt          <= '0;
    end else begin
      state              <= state_nx;
      tick               <= tick_nx;
      rest_cnt           <= rest_nx;
      vals               <= vals_nx;
      fire               <= fire_nx;
      should_spike_out_l <= spike_l_nx;
      gamma_start        <= start_nx;
      gamma_done         <= done_nx;
      fired_cnt          <= cnt_nx;
    end
  end

endmodule
